// File: rtl/stream_demux_if.sv
// Handshake bundle between one producer, the demux, and NUM_OUT consumers.
// The slave modport is the demux side; master is the producer/consumer side.
interface stream_demux_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         in_sel;
    logic [WIDTH-1:0]         in_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic                     sel_err;
    logic                     err_clr;
    logic [15:0]              xfer_cnt;

    modport slave (
        input  in_valid, in_sel, in_data, out_ready, err_clr,
        output in_ready, out_valid, out_data, sel_err, xfer_cnt
    );

    modport master (
        output in_valid, in_sel, in_data, out_ready, err_clr,
        input  in_ready, out_valid, out_data, sel_err, xfer_cnt
    );
endinterface

// File: rtl/stream_demux.sv
// 1-to-NUM_OUT stream demultiplexer with a 1-deep holding register per channel,
// a sticky out-of-range select flag and a delivered-word counter.
module stream_demux #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic           clk,
    input  logic           rst,
    stream_demux_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state    [NUM_OUT];
    state_t             state_nx [NUM_OUT];
    logic [WIDTH-1:0]   data_q   [NUM_OUT];
    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] pop;
    logic               sel_ok;
    logic               blocked;
    logic               accept;
    logic               err_q;
    logic [15:0]        cnt_q;

    // An out-of-range select never matches a channel, so it is never blocked.
    always_comb begin
        sel_ok  = 1'b0;
        blocked = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                sel_ok  = 1'b1;
                blocked = (state[i] == FULL) && !bus.out_ready[i];
            end
        end
    end

    assign bus.in_ready = !rst && !blocked;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        load = '0;
        pop  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            load[i] = accept && (bus.in_sel == SEL_W'(i));
            pop[i]  = (state[i] == FULL) && bus.out_ready[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) state[i] <= EMPTY;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) state[i] <= state_nx[i];
        end
    end

    // A load into a FULL channel only happens alongside its pop (in_ready
    // guarantees that), so FULL stays FULL with fresh data and no bubble.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            state_nx[i] = state[i];
            case (state[i])
                EMPTY:   if (load[i]) state_nx[i] = FULL;
                FULL:    if (pop[i] && !load[i]) state_nx[i] = EMPTY;
                default: state_nx[i] = EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            bus.out_valid[i]              = (state[i] == FULL);
            bus.out_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) data_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (load[i]) data_q[i] <= bus.in_data;
            end
        end
    end

    // A fresh out-of-range accept wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (accept && !sel_ok) err_q <= 1'b1;
            else if (bus.err_clr)  err_q <= 1'b0;
            if (accept && sel_ok)  cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.sel_err  = err_q;
    assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// Drives a 4-channel and a 3-channel demux with shared stimulus and checks
// both against a slot-per-channel model every cycle, plus literal expectations.
module tb_stream_demux;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_sel = '0;
    logic [7:0] in_data = '0;
    logic [3:0] out_ready = '0;
    logic       err_clr = 1'b0;
    logic       done = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    stream_demux_if #(.WIDTH(8), .NUM_OUT(4), .SEL_W(2)) if4 ();
    stream_demux_if #(.WIDTH(8), .NUM_OUT(3), .SEL_W(2)) if3 ();

    assign if4.in_valid  = in_valid;
    assign if4.in_sel    = in_sel;
    assign if4.in_data   = in_data;
    assign if4.out_ready = out_ready;
    assign if4.err_clr   = err_clr;
    assign if3.in_valid  = in_valid;
    assign if3.in_sel    = in_sel;
    assign if3.in_data   = in_data;
    assign if3.out_ready = out_ready[2:0];
    assign if3.err_clr   = err_clr;

    stream_demux #(.WIDTH(8), .NUM_OUT(4), .SEL_W(2)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    stream_demux #(.WIDTH(8), .NUM_OUT(3), .SEL_W(2)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    // Model: index 0 is the 4-channel block, index 1 the 3-channel block.
    logic        m_has  [2][4];
    logic [7:0]  m_word [2][4];
    logic        m_err  [2];
    logic [15:0] m_cnt  [2];

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic logic exp_ready(input int k);
        if (rst) return 1'b0;
        if (int'(in_sel) >= nch(k)) return 1'b1;
        return !m_has[k][in_sel] || out_ready[in_sel];
    endfunction

    function automatic logic exp_acc(input int k);
        return in_valid && exp_ready(k);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) begin
                    m_has[k][i]  <= 1'b0;
                    m_word[k][i] <= 8'h00;
                end
                m_err[k] <= 1'b0;
                m_cnt[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < nch(k); i++) begin
                    if (exp_acc(k) && int'(in_sel) == i) begin
                        m_has[k][i]  <= 1'b1;
                        m_word[k][i] <= in_data;
                    end else if (m_has[k][i] && out_ready[i]) begin
                        m_has[k][i] <= 1'b0;
                    end
                end
                if (exp_acc(k) && int'(in_sel) >= nch(k)) m_err[k] <= 1'b1;
                else if (err_clr)                         m_err[k] <= 1'b0;
                if (exp_acc(k) && int'(in_sel) < nch(k))  m_cnt[k] <= m_cnt[k] + 16'd1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    function automatic logic [3:0] exp_valid(input int k);
        logic [3:0] v = '0;
        for (int i = 0; i < nch(k); i++) v[i] = m_has[k][i];
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        logic [31:0] d = '0;
        for (int i = 0; i < nch(k); i++) d[i*8 +: 8] = m_word[k][i];
        return d;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                check("dut4 out_valid", if4.out_valid, exp_valid(0));
                check("dut4 out_data",  if4.out_data,  exp_data(0));
                check("dut4 in_ready",  if4.in_ready,  exp_ready(0));
                check("dut4 sel_err",   if4.sel_err,   m_err[0]);
                check("dut4 xfer_cnt",  if4.xfer_cnt,  m_cnt[0]);
                check("dut3 out_valid", if3.out_valid, exp_valid(1));
                check("dut3 out_data",  if3.out_data,  exp_data(1));
                check("dut3 in_ready",  if3.in_ready,  exp_ready(1));
                check("dut3 sel_err",   if3.sel_err,   m_err[1]);
                check("dut3 xfer_cnt",  if3.xfer_cnt,  m_cnt[1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        int beats;
        #2;
        check("reset in_ready", if4.in_ready, 1'b0);
        check("reset out_valid", if4.out_valid, 4'b0000);
        check("reset out_data", if4.out_data, 32'h0);
        check("reset xfer_cnt", if4.xfer_cnt, 16'h0);
        tick();
        rst = 1'b0;

        // 1) first word lands next cycle
        drive(1'b1, 2'd2, 8'hA5, 4'b0000);
        tick();
        check("t1 out_valid", if4.out_valid, 4'b0100);
        check("t1 ch2", if4.out_data[23:16], 8'hA5);
        check("t1 xfer_cnt", if4.xfer_cnt, 16'd1);

        // 2) stalled channel blocks only itself
        drive(1'b1, 2'd2, 8'h77, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t2 stall in_ready", if4.in_ready, 1'b0);
            tick();
            check("t2 ch2 held", if4.out_data[23:16], 8'hA5);
        end
        drive(1'b1, 2'd1, 8'h3C, 4'b0000);
        #1;
        check("t2 other in_ready", if4.in_ready, 1'b1);
        tick();
        check("t2 out_valid", if4.out_valid, 4'b0110);
        check("t2 ch1", if4.out_data[15:8], 8'h3C);

        // 3) pop and refill in the same cycle, then stream
        drive(1'b1, 2'd0, 8'h11, 4'b0000);
        tick();
        drive(1'b1, 2'd0, 8'h22, 4'b0001);
        #1;
        check("t3 refill in_ready", if4.in_ready, 1'b1);
        tick();
        check("t3 ch0 valid", if4.out_valid[0], 1'b1);
        check("t3 ch0", if4.out_data[7:0], 8'h22);
        beats = 0;
        for (int w = 1; w <= 8; w++) begin
            drive(1'b1, 2'd0, 8'(w), 4'b0001);
            #1;
            if (if4.in_ready) beats++;
            tick();
            check("t3 stream ch0", if4.out_data[7:0], 8'(w));
        end
        check("t3 beats", beats, 8);
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
        check("t3 drained", if4.out_valid, 4'b0000);

        // 4) out-of-range on the 3-channel block
        drive(1'b1, 2'd3, 8'hFF, 4'b0000);
        #1;
        check("t4 in_ready", if3.in_ready, 1'b1);
        tick();
        check("t4 out_valid", if3.out_valid, 3'b000);
        check("t4 sel_err", if3.sel_err, 1'b1);
        check("t4 xfer_cnt", if3.xfer_cnt, 16'd12);
        err_clr = 1'b1;
        tick();
        check("t4 clr+err", if3.sel_err, 1'b1);
        in_valid = 1'b0;
        tick();
        check("t4 clr", if3.sel_err, 1'b0);
        err_clr = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
        check("t4 dut4 xfer_cnt", if4.xfer_cnt, 16'd13);

        // 5) counter wrap
        for (int w = 0; w < 65521; w++) begin
            drive(1'b1, 2'(w % 3), 8'($urandom), 4'b1111);
            tick();
        end
        check("t5 dut4 0xFFFE", if4.xfer_cnt, 16'hFFFE);
        check("t5 dut3 0xFFFD", if3.xfer_cnt, 16'hFFFD);
        tick();
        check("t5 dut4 0xFFFF", if4.xfer_cnt, 16'hFFFF);
        tick();
        check("t5 dut4 wrap", if4.xfer_cnt, 16'h0000);
        check("t5 dut3 0xFFFF", if3.xfer_cnt, 16'hFFFF);

        // 6) reset with every channel full
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 2'(c), 8'(8'h40 + c), 4'b0000);
            tick();
        end
        check("t6 all full", if4.out_valid, 4'b1111);
        drive(1'b1, 2'd0, 8'h99, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        check("t6 rst out_valid", if4.out_valid, 4'b0000);
        check("t6 rst in_ready", if4.in_ready, 1'b0);
        check("t6 rst xfer_cnt", if4.xfer_cnt, 16'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, 2'd3, 8'h5A, 4'b0000);
        #1;
        check("t6 post in_ready", if4.in_ready, 1'b1);
        tick();
        check("t6 post out_valid", if4.out_valid, 4'b1000);
        check("t6 post ch3", if4.out_data[31:24], 8'h5A);
        check("t6 post xfer_cnt", if4.xfer_cnt, 16'd1);

        // Randomized traffic with occasional clears and mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            if (rst) rst = 1'b0;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  8'($urandom), 4'($urandom));
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        err_clr = 1'b0;
        @(negedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
